ahb_master_if: RTL and testbench
================================

Name: ahb_master_if

Overview:
- AHB master-side bus interface. Sits directly upstream of ahb_slave_if and drives its ahb_* inputs.
- Converts a simple command/beat interface from a local requester into legal AHB transfers: SINGLE, INCR, INCR4/8/16 and WRAP4/8/16.
- Generates HTRANS sequencing and burst addresses, and handles wait states, ERROR responses and wait timeouts.

Parameters:
- AHB_DATA_WIDTH, 32: data bus width; power of two, 8..1024.
- AHB_ADDR_WIDTH, 32: address bus width.
- AHB_WAIT_TIMEOUT, 6: consecutive ahb_ready_in-low data-phase cycles before the master aborts.

Ports:
- ahb_clk_in  in  1  bus clock; all logic on rising edge.
- ahb_rst_in  in  1  asynchronous active-high reset.
- cmd_valid_in  in  1  command request.
- cmd_ready_out  out  1  command accepted when valid&ready.
- cmd_addr_in  in  AHB_ADDR_WIDTH  start address.
- cmd_write_in  in  1  1 = write.
- cmd_size_in  in  3  HSIZE encoding.
- cmd_burst_in  in  3  HBURST encoding.
- cmd_len_in  in  4  beats-1; used only for INCR.
- beat_wdata_in  in  AHB_DATA_WIDTH  write data for the next beat.
- beat_wvalid_in  in  1  write data available (used only with AHB_BUSY_EN).
- beat_wready_out  out  1  pulse: beat_wdata_in consumed this cycle.
- beat_rdata_out  out  AHB_DATA_WIDTH  read data.
- beat_rvalid_out  out  1  pulse per completed read beat.
- done_out  out  1  pulse: command completed (OKAY or aborted).
- error_out  out  1  pulse with done_out on ERROR response, timeout or rejected command.
- ahb_addr_out  out  AHB_ADDR_WIDTH  HADDR.
- ahb_burst_out  out  3  HBURST.
- ahb_size_out  out  3  HSIZE.
- ahb_trans_out  out  2  HTRANS.
- ahb_write_out  out  1  HWRITE.
- ahb_wdata_out  out  AHB_DATA_WIDTH  HWDATA.
- ahb_rdata_in  in  AHB_DATA_WIDTH  HRDATA.
- ahb_ready_in  in  1  HREADY.
- ahb_resp_in  in  1  HRESP; 1 = ERROR.

Behaviour:
- Clock/reset: one clock, ahb_clk_in. Reset ahb_rst_in is asynchronous, active-high.
- Reset values: all registered outputs 0; ahb_trans_out = IDLE(0); cmd_ready_out = 0 while reset is asserted, 1 in the first IDLE cycle after release.
- Reset mid-burst: outputs drop to reset values immediately; no done_out.
- States: IDLE, ADDR (NONSEQ issued), BURST (SEQ/BUSY), LAST (final data phase), ERR1, ERR2.
- cmd_ready_out = 1 only in IDLE.
- Command validation on acceptance:
  - Reject if cmd_size_in > log2(AHB_DATA_WIDTH/8), or cmd_addr_in is not aligned to 1<<cmd_size_in.
  - Reject response: done_out + error_out one cycle later; no bus activity.
- Beat count: SINGLE = 1; INCR = cmd_len_in+1; INCR4/WRAP4 = 4; INCR8/WRAP8 = 8; INCR16/WRAP16 = 16.
- Pipelining:
  - The cycle after acceptance drives NONSEQ with the start address.
  - Address/control advance only on a cycle with ahb_ready_in=1.
  - The beat n address phase overlaps the beat n-1 data phase.
  - Subsequent beats are SEQ; after the last address is accepted, drive IDLE.
- Address increment: incr = 1<<size.
  - INCR*: addr+incr.
  - WRAP*: mask = (beats<<size)-1; next = (addr & ~mask) | ((addr+incr) & mask).
- INCR 1KB boundary: if the next address crosses a 1KB boundary, issue NONSEQ (not SEQ) at the boundary; burst stays INCR.
- Writes:
  - beat_wdata_in is sampled and beat_wready_out pulses on the cycle that beat's address phase is accepted.
  - ahb_wdata_out holds the data through that beat's data phase until ahb_ready_in=1.
- Reads: beat_rdata_out <= ahb_rdata_in and beat_rvalid_out pulses when ahb_ready_in=1 in a read data phase with ahb_resp_in=0.
- ERROR response:
  - First cycle (ready=0, resp=1): drive IDLE next and cancel remaining beats.
  - Second cycle (ready=1, resp=1): done_out + error_out, return to IDLE.
  - A pending pipelined address beat is abandoned.
- Timeout:
  - The counter, width $clog2(AHB_WAIT_TIMEOUT+1), resets whenever ahb_ready_in=1.
  - On reaching AHB_WAIT_TIMEOUT: drive IDLE, done_out + error_out, go to IDLE.
- Completion: done_out pulses in the cycle after the last data phase completes OKAY.
- Simultaneous cmd_valid_in and done_out: the command is not accepted until the next IDLE cycle; minimum one IDLE bus cycle between commands.

Optional Feature:
- Macro AHB_BUSY_EN.
- Defined:
  - For a write SEQ beat with beat_wvalid_in=0, drive BUSY with the next address/control held.
  - Resume SEQ when beat_wvalid_in=1. beat_wready_out is not pulsed while BUSY.
  - The first beat waits in IDLE (no NONSEQ) until valid.
- Undefined:
  - beat_wvalid_in is ignored and BUSY is never issued.
  - The requester must present data whenever beat_wready_out pulses.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS localparams IDLE/BUSY/NONSEQ/SEQ.
  - HBURST localparams SINGLE..INCR16.
  - Master state encoding.
  - 1KB boundary constant.
- One sub-module, ahb_burst_addr_gen: combinational next-address and beat-count from addr/size/burst/len, including wrap and 1KB-cross flag.

Test Plan:
- INCR4 write at 0x100, size=2, ready always 1 -> HTRANS NONSEQ,SEQ,SEQ,SEQ,IDLE; HADDR 0x100,0x104,0x108,0x10C; four beat_wready_out pulses; done_out, error_out=0.
- WRAP4 read at 0x38, size=2 -> HADDR 0x38,0x3C,0x30,0x34; four beat_rvalid_out pulses carrying the ahb_rdata_in values.
- INCR write, len=3, start 0x3F8, size=2 -> HADDR 0x3F8,0x3FC (SEQ), then NONSEQ at 0x400, SEQ 0x404.
- INCR8 read, ERROR response on beat 3 (ready 0/resp 1 then ready 1/resp 1) -> IDLE driven next, no further beats, done_out+error_out, exactly 2 rvalid pulses.
- SINGLE read with ready held 0 for 6 cycles, AHB_WAIT_TIMEOUT=6 -> done_out+error_out on the 6th cycle, trans IDLE; size=3 on a 32-bit bus -> immediate reject, no NONSEQ.
- With AHB_BUSY_EN: INCR4 write with wvalid low for 2 cycles before beat 2 -> BUSY,BUSY inserted, HADDR held at 0x104, then SEQ resumes.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB master constants.
// HTRANS/HBURST codes, FSM states, 1KB boundary.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_BURST = 3'd2;
  localparam logic [2:0] ST_LAST  = 3'd3;
  localparam logic [2:0] ST_ERR1  = 3'd4;
  localparam logic [2:0] ST_ERR2  = 3'd5;

  // INCR bursts may not cross a 2**KB_SHIFT byte boundary
  localparam int KB_SHIFT = 10;

  function automatic logic is_wrap(input logic [2:0] b);
    return (b == HBURST_WRAP4) ||
           (b == HBURST_WRAP8) ||
           (b == HBURST_WRAP16);
  endfunction

endpackage

// File: rtl/ahb_burst_addr_gen.sv
// ahb_burst_addr_gen: next burst address and beat count.
// Handles wrap masking and flags 1KB crossings on INCR.
module ahb_burst_addr_gen
  import ahb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [2:0]    burst,
  input  logic [3:0]    len,
  output logic [AW-1:0] next_addr,
  output logic [4:0]    beats,
  output logic          cross_1k
);

  logic [AW-1:0] one;
  logic [AW-1:0] incr;
  logic [AW-1:0] sum;
  logic [AW-1:0] wmask;
  logic          wrap;

  assign one = {{(AW-1){1'b0}}, 1'b1};

  // beats per burst type; INCR uses the requested length
  always_comb begin
    beats = 5'd1;
    unique case (burst)
      HBURST_INCR:   beats = {1'b0, len} + 5'd1;
      HBURST_WRAP4,
      HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,
      HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16,
      HBURST_INCR16: beats = 5'd16;
      default:       beats = 5'd1;
    endcase
  end

  // wrap keeps the upper bits, increments inside the window
  always_comb begin
    wrap      = is_wrap(burst);
    incr      = one << size;
    sum       = addr + incr;
    wmask     = (AW'(beats) << size) - one;
    next_addr = sum;
    if (wrap)
      next_addr = (addr & ~wmask) | (sum & wmask);
    cross_1k  = !wrap &&
      ((next_addr >> KB_SHIFT) != (addr >> KB_SHIFT));
  end

endmodule

// File: rtl/ahb_master_if.sv
// ahb_master_if: command/beat to AHB master bridge.
// Optional BUSY insertion under macro AHB_BUSY_EN.
module ahb_master_if
  import ahb_pkg::*;
#(
  parameter int AHB_DATA_WIDTH   = 32,
  parameter int AHB_ADDR_WIDTH   = 32,
  parameter int AHB_WAIT_TIMEOUT = 6
) (
  input  logic                      ahb_clk_in,
  input  logic                      ahb_rst_in,
  input  logic                      cmd_valid_in,
  output logic                      cmd_ready_out,
  input  logic [AHB_ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic                      cmd_write_in,
  input  logic [2:0]                cmd_size_in,
  input  logic [2:0]                cmd_burst_in,
  input  logic [3:0]                cmd_len_in,
  input  logic [AHB_DATA_WIDTH-1:0] beat_wdata_in,
  input  logic                      beat_wvalid_in,
  output logic                      beat_wready_out,
  output logic [AHB_DATA_WIDTH-1:0] beat_rdata_out,
  output logic                      beat_rvalid_out,
  output logic                      done_out,
  output logic                      error_out,
  output logic [AHB_ADDR_WIDTH-1:0] ahb_addr_out,
  output logic [2:0]                ahb_burst_out,
  output logic [2:0]                ahb_size_out,
  output logic [1:0]                ahb_trans_out,
  output logic                      ahb_write_out,
  output logic [AHB_DATA_WIDTH-1:0] ahb_wdata_out,
  input  logic [AHB_DATA_WIDTH-1:0] ahb_rdata_in,
  input  logic                      ahb_ready_in,
  input  logic                      ahb_resp_in
);

  localparam int AW = AHB_ADDR_WIDTH;
  localparam int TW = $clog2(AHB_WAIT_TIMEOUT + 1);
  localparam logic [2:0] MAX_SIZE =
    3'($clog2(AHB_DATA_WIDTH / 8));

  logic [2:0]    state;
  logic [1:0]    trans_q;
  logic [3:0]    len_q;
  logic [4:0]    beats_left;
  logic          dp_active;
  logic          dp_write;
  logic [TW-1:0] wait_cnt;

  logic [AW-1:0] g_addr;
  logic [2:0]    g_size;
  logic [2:0]    g_burst;
  logic [3:0]    g_len;
  logic [AW-1:0] next_addr;
  logic [4:0]    beats;
  logic          cross_1k;

  logic [AW-1:0] one;
  logic [AW-1:0] align_mask;
  logic          cmd_bad;
  logic          accept;
  logic          active;
  logic          hold;
  logic          addr_acc;
  logic          dp_done;
  logic          err_first;
  logic          tmo;

  // command fields feed the generator until accepted
  assign g_addr  = (state == ST_IDLE) ? cmd_addr_in
                                      : ahb_addr_out;
  assign g_size  = (state == ST_IDLE) ? cmd_size_in
                                      : ahb_size_out;
  assign g_burst = (state == ST_IDLE) ? cmd_burst_in
                                      : ahb_burst_out;
  assign g_len   = (state == ST_IDLE) ? cmd_len_in
                                      : len_q;

  ahb_burst_addr_gen #(
    .AW (AW)
  ) u_gen (
    .addr      (g_addr),
    .size      (g_size),
    .burst     (g_burst),
    .len       (g_len),
    .next_addr (next_addr),
    .beats     (beats),
    .cross_1k  (cross_1k)
  );

  assign one        = {{(AW-1){1'b0}}, 1'b1};
  assign align_mask = (one << cmd_size_in) - one;
  assign cmd_bad    = (cmd_size_in > MAX_SIZE) ||
                      ((cmd_addr_in & align_mask) != '0);

  assign cmd_ready_out = !ahb_rst_in &&
                         (state == ST_IDLE) && !done_out;
  assign accept = cmd_valid_in && cmd_ready_out;

`ifdef AHB_BUSY_EN
  assign hold = ahb_write_out && !beat_wvalid_in &&
                trans_q[1];
`else
  logic unused_wvalid;
  assign unused_wvalid = beat_wvalid_in;
  assign hold = 1'b0;
`endif

  // stalled SEQ shows as BUSY, stalled NONSEQ as IDLE
  assign ahb_trans_out = !hold ? trans_q :
    ((trans_q == HTRANS_SEQ) ? HTRANS_BUSY : HTRANS_IDLE);

  assign addr_acc  = ahb_ready_in && trans_q[1] && !hold;
  assign dp_done   = ahb_ready_in && dp_active;
  assign err_first = dp_active && !ahb_ready_in &&
                     ahb_resp_in;
  assign active    = (state == ST_ADDR) ||
                     (state == ST_BURST) ||
                     (state == ST_LAST) ||
                     (state == ST_ERR1);
  assign tmo       = active && !ahb_ready_in &&
    (wait_cnt == TW'(AHB_WAIT_TIMEOUT - 1));

  assign beat_wready_out = addr_acc && ahb_write_out;

  // consecutive wait-state counter
  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in)
      wait_cnt <= '0;
    else if (!active || ahb_ready_in)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + TW'(1);
  end

  // capture read data on each OKAY read data phase
  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      beat_rdata_out  <= '0;
      beat_rvalid_out <= 1'b0;
    end else begin
      beat_rvalid_out <= 1'b0;
      if (dp_done && !dp_write && !ahb_resp_in) begin
        beat_rdata_out  <= ahb_rdata_in;
        beat_rvalid_out <= 1'b1;
      end
    end
  end

  // transfer sequencing, burst addressing and completion
  always_ff @(posedge ahb_clk_in or posedge ahb_rst_in) begin
    if (ahb_rst_in) begin
      state         <= ST_IDLE;
      trans_q       <= HTRANS_IDLE;
      len_q         <= '0;
      beats_left    <= '0;
      dp_active     <= 1'b0;
      dp_write      <= 1'b0;
      done_out      <= 1'b0;
      error_out     <= 1'b0;
      ahb_addr_out  <= '0;
      ahb_burst_out <= '0;
      ahb_size_out  <= '0;
      ahb_write_out <= 1'b0;
      ahb_wdata_out <= '0;
    end else begin
      done_out  <= 1'b0;
      error_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept && cmd_bad) begin
            done_out  <= 1'b1;
            error_out <= 1'b1;
          end else if (accept) begin
            ahb_addr_out  <= cmd_addr_in;
            ahb_write_out <= cmd_write_in;
            ahb_size_out  <= cmd_size_in;
            ahb_burst_out <= cmd_burst_in;
            len_q         <= cmd_len_in;
            beats_left    <= beats - 5'd1;
            trans_q       <= HTRANS_NONSEQ;
            state         <= ST_ADDR;
          end
        end
        ST_ADDR, ST_BURST, ST_LAST: begin
          if (err_first) begin
            trans_q   <= HTRANS_IDLE;
            dp_active <= 1'b0;
            state     <= ST_ERR1;
          end else if (tmo) begin
            trans_q   <= HTRANS_IDLE;
            dp_active <= 1'b0;
            done_out  <= 1'b1;
            error_out <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            if (dp_done)
              dp_active <= 1'b0;
            if (addr_acc) begin
              dp_active <= 1'b1;
              dp_write  <= ahb_write_out;
              if (ahb_write_out)
                ahb_wdata_out <= beat_wdata_in;
              if (beats_left != 5'd0) begin
                ahb_addr_out <= next_addr;
                trans_q      <= cross_1k ? HTRANS_NONSEQ
                                         : HTRANS_SEQ;
                beats_left   <= beats_left - 5'd1;
                state        <= ST_BURST;
              end else begin
                trans_q <= HTRANS_IDLE;
                state   <= ST_LAST;
              end
            end
            if ((state == ST_LAST) && dp_done) begin
              done_out <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_ERR1: begin
          if (ahb_ready_in) begin
            done_out  <= 1'b1;
            error_out <= 1'b1;
            state     <= ST_ERR2;
          end else if (tmo) begin
            done_out  <= 1'b1;
            error_out <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_ERR2: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_if.sv
// tb_ahb_master_if: directed bench for ahb_master_if.
// Optional BUSY case compiled with AHB_BUSY_EN.
module tb_ahb_master_if;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [2:0]  cmd_size;
  logic [2:0]  cmd_burst;
  logic [3:0]  cmd_len;
  logic [31:0] wdata_in;
  logic        wvalid;
  logic        wready;
  logic [31:0] rdata_out;
  logic        rvalid;
  logic        done;
  logic        err;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int errors = 0;
  int checks = 0;
  int rv_cnt = 0;
  int base;

  ahb_master_if #(
    .AHB_DATA_WIDTH   (32),
    .AHB_ADDR_WIDTH   (32),
    .AHB_WAIT_TIMEOUT (6)
  ) dut (
    .ahb_clk_in      (clk),
    .ahb_rst_in      (rst),
    .cmd_valid_in    (cmd_valid),
    .cmd_ready_out   (cmd_ready),
    .cmd_addr_in     (cmd_addr),
    .cmd_write_in    (cmd_write),
    .cmd_size_in     (cmd_size),
    .cmd_burst_in    (cmd_burst),
    .cmd_len_in      (cmd_len),
    .beat_wdata_in   (wdata_in),
    .beat_wvalid_in  (wvalid),
    .beat_wready_out (wready),
    .beat_rdata_out  (rdata_out),
    .beat_rvalid_out (rvalid),
    .done_out        (done),
    .error_out       (err),
    .ahb_addr_out    (haddr),
    .ahb_burst_out   (hburst),
    .ahb_size_out    (hsize),
    .ahb_trans_out   (htrans),
    .ahb_write_out   (hwrite),
    .ahb_wdata_out   (hwdata),
    .ahb_rdata_in    (hrdata),
    .ahb_ready_in    (hready),
    .ahb_resp_in     (hresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rvalid === 1'b1) rv_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  // present a command in an IDLE cycle; returns in cycle c1
  task automatic issue(input logic [31:0] a,
                       input logic        w,
                       input logic [2:0]  sz,
                       input logic [2:0]  bu,
                       input logic [3:0]  ln);
    cmd_addr  = a;
    cmd_write = w;
    cmd_size  = sz;
    cmd_burst = bu;
    cmd_len   = ln;
    cmd_valid = 1'b1;
    settle();
    chk("cmd_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] wa [4];
    logic [31:0] ia [4];
    logic [1:0]  it [4];
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_size  = '0;
    cmd_burst = '0;
    cmd_len   = '0;
    wdata_in  = '0;
    wvalid    = 1'b1;
    hrdata    = '0;
    hready    = 1'b1;
    hresp     = 1'b0;

    // reset state
    #12;
    chk("rst_trans", htrans, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", haddr, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", cmd_ready, 1);

    // INCR4 write at 0x100
    issue(32'h100, 1'b1, 3'd2, 3'd3, 4'd0);
    for (int i = 0; i < 4; i++) begin
      wdata_in = 32'hA000_0000 + i;
      settle();
      chk($sformatf("t1_trans%0d", i), htrans,
          (i == 0) ? 2 : 3);
      chk($sformatf("t1_addr%0d", i), haddr, 32'h100 + 4 * i);
      chk($sformatf("t1_wready%0d", i), wready, 1);
      if (i > 0)
        chk($sformatf("t1_wdata%0d", i), hwdata,
            32'hA000_0000 + i - 1);
      tick();
    end
    settle();
    chk("t1_idle", htrans, 0);
    chk("t1_wready_off", wready, 0);
    chk("t1_wdata3", hwdata, 32'hA000_0003);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    chk("t1_err", err, 0);
    chk("t1_rdy_in_done", cmd_ready, 0);
    tick();
    chk("t1_rdy_back", cmd_ready, 1);

    // WRAP4 read at 0x38
    wa = '{32'h38, 32'h3C, 32'h30, 32'h34};
    base = rv_cnt;
    issue(32'h38, 1'b0, 3'd2, 3'd2, 4'd0);
    for (int i = 0; i < 5; i++) begin
      if (i >= 1) hrdata = 32'hC0DE_0000 + i - 1;
      settle();
      if (i < 4) begin
        chk($sformatf("t2_trans%0d", i), htrans,
            (i == 0) ? 2 : 3);
        chk($sformatf("t2_addr%0d", i), haddr, wa[i]);
      end else begin
        chk("t2_idle", htrans, 0);
      end
      if (i >= 2) begin
        chk($sformatf("t2_rv%0d", i), rvalid, 1);
        chk($sformatf("t2_rd%0d", i), rdata_out,
            32'hC0DE_0000 + i - 2);
      end
      tick();
    end
    chk("t2_rv_last", rvalid, 1);
    chk("t2_rd_last", rdata_out, 32'hC0DE_0003);
    chk("t2_done", done, 1);
    chk("t2_err", err, 0);
    tick();
    chk("t2_rv_count", rv_cnt - base, 4);

    // INCR len=3 write across the 1KB boundary
    ia = '{32'h3F8, 32'h3FC, 32'h400, 32'h404};
    it = '{2'd2, 2'd3, 2'd2, 2'd3};
    issue(32'h3F8, 1'b1, 3'd2, 3'd1, 4'd3);
    for (int i = 0; i < 4; i++) begin
      wdata_in = 32'hB000_0000 + i;
      settle();
      chk($sformatf("t3_trans%0d", i), htrans, it[i]);
      chk($sformatf("t3_addr%0d", i), haddr, ia[i]);
      chk($sformatf("t3_burst%0d", i), hburst, 1);
      tick();
    end
    chk("t3_idle", htrans, 0);
    tick();
    chk("t3_done", done, 1);
    chk("t3_err", err, 0);
    tick();

    // INCR8 read, ERROR on beat 3
    base = rv_cnt;
    issue(32'h200, 1'b0, 3'd2, 3'd5, 4'd0);
    chk("t4_ns", htrans, 2);
    tick();
    hrdata = 32'h1111_0000;
    chk("t4_a1", haddr, 32'h204);
    tick();
    hrdata = 32'h1111_0001;
    chk("t4_a2", haddr, 32'h208);
    tick();
    hready = 1'b0;
    hresp  = 1'b1;
    settle();
    chk("t4_a3", haddr, 32'h20C);
    chk("t4_t3", htrans, 3);
    chk("t4_rd2", rdata_out, 32'h1111_0001);
    tick();
    chk("t4_idle", htrans, 0);
    chk("t4_no_done", done, 0);
    hready = 1'b1;
    hresp  = 1'b1;
    tick();
    chk("t4_done", done, 1);
    chk("t4_err", err, 1);
    chk("t4_idle2", htrans, 0);
    hresp = 1'b0;
    tick();
    chk("t4_rv_count", rv_cnt - base, 2);
    chk("t4_done_off", done, 0);
    chk("t4_rdy", cmd_ready, 1);

    // SINGLE read, timeout after six wait states
    issue(32'h40, 1'b0, 3'd2, 3'd0, 4'd0);
    chk("t5_ns", htrans, 2);
    tick();
    for (int i = 0; i < 6; i++) begin
      hready = 1'b0;
      settle();
      chk($sformatf("t5_wait%0d", i), done, 0);
      chk($sformatf("t5_trans%0d", i), htrans, 0);
      tick();
    end
    chk("t5_done", done, 1);
    chk("t5_err", err, 1);
    chk("t5_trans", htrans, 0);
    chk("t5_no_rv", rvalid, 0);
    hready = 1'b1;
    tick();

    // size=3 on a 32-bit bus is rejected
    issue(32'h0, 1'b0, 3'd3, 3'd0, 4'd0);
    chk("t6_done", done, 1);
    chk("t6_err", err, 1);
    chk("t6_trans", htrans, 0);
    chk("t6_rdy", cmd_ready, 0);
    tick();
    chk("t6_trans2", htrans, 0);
    chk("t6_done_off", done, 0);

    // misaligned write rejected; next cmd waits out done
    issue(32'h102, 1'b1, 3'd2, 3'd0, 4'd0);
    chk("t7_done", done, 1);
    chk("t7_err", err, 1);
    chk("t7_wready", wready, 0);
    cmd_addr  = 32'h80;
    cmd_write = 1'b0;
    cmd_size  = 3'd2;
    cmd_burst = 3'd0;
    cmd_valid = 1'b1;
    settle();
    chk("t7_rdy_blocked", cmd_ready, 0);
    tick();
    chk("t7_not_taken", htrans, 0);
    chk("t7_rdy_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    chk("t7_ns", htrans, 2);
    chk("t7_addr", haddr, 32'h80);
    tick();
    tick();
    chk("t7_done2", done, 1);
    chk("t7_err2", err, 0);
    tick();

    // reset in the middle of a burst
    issue(32'h100, 1'b0, 3'd2, 3'd3, 4'd0);
    tick();
    chk("t8_seq", htrans, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("t8_trans", htrans, 0);
    chk("t8_addr", haddr, 0);
    chk("t8_done", done, 0);
    chk("t8_rdy", cmd_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("t8_rdy_back", cmd_ready, 1);
    chk("t8_no_done", done, 0);

`ifdef AHB_BUSY_EN
    // INCR4 write with two BUSY cycles before beat 2
    wvalid = 1'b1;
    issue(32'h100, 1'b1, 3'd2, 3'd3, 4'd0);
    wdata_in = 32'hD000_0000;
    settle();
    chk("t9_ns", htrans, 2);
    chk("t9_wr0", wready, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      wvalid   = 1'b0;
      wdata_in = 32'hD000_0001;
      settle();
      chk($sformatf("t9_busy%0d", i), htrans, 1);
      chk($sformatf("t9_hold%0d", i), haddr, 32'h104);
      chk($sformatf("t9_nowr%0d", i), wready, 0);
      tick();
    end
    wvalid = 1'b1;
    settle();
    chk("t9_seq1", htrans, 3);
    chk("t9_a1", haddr, 32'h104);
    chk("t9_wr1", wready, 1);
    tick();
    wdata_in = 32'hD000_0002;
    settle();
    chk("t9_a2", haddr, 32'h108);
    chk("t9_wd1", hwdata, 32'hD000_0001);
    tick();
    wdata_in = 32'hD000_0003;
    settle();
    chk("t9_a3", haddr, 32'h10C);
    tick();
    chk("t9_idle", htrans, 0);
    tick();
    chk("t9_done", done, 1);
    chk("t9_err", err, 0);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
